// File: rtl/turn_ring_controller.sv
// turn_ring_controller: turn-order controller for an N-player button game.
//
// Tracks whose turn it is, the direction of play and each player's lives.
// A rising edge on the current player's button is a legal move and applies
// the action code on that player's act field. A rising edge from any other
// alive player is a foul and costs that player a life. A player at 0 lives
// is eliminated and is never landed on again. When one player remains, the
// game ends and that player is reported as the winner.
//
// Optional feature macro: TURN_TIMEOUT_EN
//   When defined, a turn that sees no legal press for TIMEOUT cycles costs
//   the current player a life and advances as NEXT. When undefined, no
//   counter is built and TIMEOUT is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      level; starts a new game from IDLE or OVER
//   press      [NUM_PLAYERS]        per-player button level
//   act        [NUM_PLAYERS*ACT_W]  player i action at [i*ACT_W +: ACT_W]
//   turn       [PW]                 current player index
//   dir        0 ascending, 1 descending
//   alive      [NUM_PLAYERS]        1 = still in game
//   lives      [NUM_PLAYERS*LW]     player i at [i*LW +: LW]
//   foul       one-cycle pulse, at least one life lost
//   foul_mask  [NUM_PLAYERS]        players that lost a life (0 unless foul)
//   state_out  [2]                  0 IDLE, 1 PLAY, 2 OVER
//   winner     [PW]                 last alive player in OVER, else 0

// Per-player lives/alive tracker.
module trc_lane #(
  parameter int LIVES = 2,
  parameter int LW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          loss,
  output logic [LW-1:0] lives,
  output logic          alive,
  output logic          alive_nxt
);
  logic [LW-1:0] lives_q, lives_nxt;
  logic          alive_q;

  // alive_nxt is exported so the turn search sees this cycle's eliminations.
  always_comb begin
    lives_nxt = lives_q;
    alive_nxt = alive_q;
    if (init) begin
      lives_nxt = LW'(LIVES);
      alive_nxt = 1'b1;
    end else if (loss && lives_q != '0) begin
      lives_nxt = lives_q - LW'(1);
      if (lives_q == LW'(1)) alive_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lives_q <= LW'(LIVES);
      alive_q <= 1'b1;
    end else begin
      lives_q <= lives_nxt;
      alive_q <= alive_nxt;
    end
  end

  assign lives = lives_q;
  assign alive = alive_q;
endmodule

module turn_ring_controller #(
  parameter int NUM_PLAYERS = 6,
  parameter int ACT_W       = 3,
  parameter int LIVES       = 2,
  parameter int TIMEOUT     = 1000,
  localparam int PW = $clog2(NUM_PLAYERS),
  localparam int LW = $clog2(LIVES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_PLAYERS-1:0]       press,
  input  logic [NUM_PLAYERS*ACT_W-1:0] act,
  output logic [PW-1:0]               turn,
  output logic                        dir,
  output logic [NUM_PLAYERS-1:0]       alive,
  output logic [NUM_PLAYERS*LW-1:0]    lives,
  output logic                        foul,
  output logic [NUM_PLAYERS-1:0]       foul_mask,
  output logic [1:0]                  state_out,
  output logic [PW-1:0]               winner
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_SKIP = 2'b01;
  localparam logic [1:0] OP_REV  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  state_t                 state, state_nxt;
  logic [PW-1:0]          turn_q, turn_nxt, winner_q, winner_nxt, last_idx;
  logic                   dir_q, dir_nxt, foul_q;
  logic [NUM_PLAYERS-1:0] press_q, edges, ev, turn_oh, fouls, loss;
  logic [NUM_PLAYERS-1:0] alive_cur, alive_nxt, fmask_q;
  logic                   legal, init, tmo;
  logic [1:0]             op;
  int                     n_alive;

  // Index k steps away from cur in direction d, modulo NUM_PLAYERS.
  function automatic logic [PW-1:0] step_idx(input logic [PW-1:0] cur,
                                             input logic d, input int k);
    int t;
    if (!d) t = (int'(cur) + k) % NUM_PLAYERS;
    else    t = (int'(cur) + NUM_PLAYERS - k) % NUM_PLAYERS;
    return t[PW-1:0];
  endfunction

  // nth alive player walking from cur in direction d. The walk covers a
  // full lap, so with two alive a second hop lands back on the mover.
  function automatic logic [PW-1:0] find_alive(input logic [PW-1:0] cur,
                                               input logic d,
                                               input logic [NUM_PLAYERS-1:0] mask,
                                               input int nth);
    logic [PW-1:0] res, idx;
    int hits;
    res  = cur;
    hits = 0;
    for (int k = 1; k <= NUM_PLAYERS; k++) begin
      idx = step_idx(cur, d, k);
      if (mask[idx] && hits < nth) begin
        hits++;
        if (hits == nth) res = idx;
      end
    end
    return res;
  endfunction

  // Edge detection; only alive players in PLAY count.
  assign edges = press & ~press_q;
  assign ev    = (state == PLAY) ? (edges & alive_cur) : '0;

  always_comb begin
    turn_oh = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) turn_oh[i] = (turn_q == PW'(i));
  end

  assign legal = ev[turn_q];
  assign op    = act[int'(turn_q)*ACT_W +: 2];
  assign fouls = ev & ~turn_oh;
  assign loss  = fouls | (tmo ? turn_oh : '0);

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // A legal press in the expiring cycle wins over the timeout.
  assign tmo = (state == PLAY) && !legal && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) tcnt <= '0;
    else if (state != PLAY || turn_nxt != turn_q || tmo) tcnt <= '0;
    else tcnt <= tcnt + TW'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  // Only bits [1:0] of each action field are decoded.
  logic unused_act;
  assign unused_act = ^act;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    trc_lane #(.LIVES(LIVES), .LW(LW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .init     (init),
      .loss     (loss[i]),
      .lives    (lives[i*LW +: LW]),
      .alive    (alive_cur[i]),
      .alive_nxt(alive_nxt[i])
    );
  end

  // Survivor count after this cycle's eliminations.
  always_comb begin
    n_alive  = 0;
    last_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive_nxt[i]) begin
        n_alive++;
        last_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    turn_nxt   = turn_q;
    dir_nxt    = dir_q;
    winner_nxt = winner_q;
    init       = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt  = PLAY;
          turn_nxt   = '0;
          dir_nxt    = 1'b0;
          winner_nxt = '0;
          init       = 1'b1;
        end
      end
      PLAY: begin
        if (legal) begin
          case (op)
            OP_NEXT: turn_nxt = find_alive(turn_q, dir_q, alive_nxt, 1);
            OP_SKIP: turn_nxt = find_alive(turn_q, dir_q, alive_nxt, 2);
            OP_REV: begin
              dir_nxt  = ~dir_q;
              turn_nxt = find_alive(turn_q, ~dir_q, alive_nxt, 1);
            end
            OP_HOLD: turn_nxt = turn_q;
            default: turn_nxt = turn_q;
          endcase
        end else if (tmo) begin
          turn_nxt = find_alive(turn_q, dir_q, alive_nxt, 1);
        end
        if (n_alive == 1) begin
          state_nxt  = OVER;
          winner_nxt = last_idx;
          turn_nxt   = last_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    press_q <= press;
    if (reset) begin
      state    <= IDLE;
      turn_q   <= '0;
      dir_q    <= 1'b0;
      winner_q <= '0;
      foul_q   <= 1'b0;
      fmask_q  <= '0;
    end else begin
      state    <= state_nxt;
      turn_q   <= turn_nxt;
      dir_q    <= dir_nxt;
      winner_q <= winner_nxt;
      foul_q   <= |loss;
      fmask_q  <= loss;
    end
  end

  assign turn      = turn_q;
  assign dir       = dir_q;
  assign alive     = alive_cur;
  assign foul      = foul_q;
  assign foul_mask = fmask_q;
  assign state_out = state;
  assign winner    = winner_q;
endmodule

// File: tb/tb_turn_ring_controller.sv
// Bench for turn_ring_controller (6 players, 2 lives). Each scenario task
// drives a table of press/act/start rows, pushes the expected outputs to a
// scoreboard queue and pops them against the observed outputs.
module tb_turn_ring_controller;
  localparam logic [1:0] NX = 2'd0, SK = 2'd1, RV = 2'd2, HD = 2'd3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  press;
  logic [17:0] act;
  logic [2:0]  turn, winner;
  logic        dir, foul;
  logic [5:0]  alive, foul_mask;
  logic [11:0] lives;
  logic [1:0]  state_out;

  always #5 clk = ~clk;

  turn_ring_controller #(.NUM_PLAYERS(6), .ACT_W(3), .LIVES(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .press(press), .act(act),
    .turn(turn), .dir(dir), .alive(alive), .lives(lives), .foul(foul),
    .foul_mask(foul_mask), .state_out(state_out), .winner(winner)
  );

  typedef struct packed {
    logic [2:0]  turn;
    logic        dir;
    logic [5:0]  alive;
    logic [11:0] lives;
    logic        foul;
    logic [5:0]  fmask;
    logic [1:0]  st;
    logic [2:0]  win;
  } obs_t;

  typedef struct packed {
    logic [5:0] pr;
    logic [1:0] op;
    logic       st;
    obs_t       e;
  } row_t;

  obs_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic obs_t mk(input logic [2:0] t, input logic d, input logic [5:0] a,
                              input logic [11:0] l, input logic f, input logic [5:0] m,
                              input logic [1:0] s, input logic [2:0] w);
    obs_t o;
    o.turn = t; o.dir = d; o.alive = a; o.lives = l;
    o.foul = f; o.fmask = m; o.st = s; o.win = w;
    return o;
  endfunction

  function automatic row_t mkrow(input logic [5:0] pr, input logic [1:0] op,
                                 input logic st, input obs_t e);
    row_t r;
    r.pr = pr; r.op = op; r.st = st; r.e = e;
    return r;
  endfunction

  function automatic obs_t sample();
    return mk(turn, dir, alive, lives, foul, foul_mask, state_out, winner);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press cycle then release cycle; the release cycle must show the same
  // state with the foul pulse gone.
  task automatic drive(input row_t r, output obs_t g1, output obs_t g2);
    obs_t q;
    press = r.pr;
    act   = {6{1'b0, r.op}};
    start = r.st;
    sb.push_back(r.e);
    tick();
    g1 = sample();
    press = '0;
    start = 1'b0;
    q = r.e;
    q.foul  = 1'b0;
    q.fmask = '0;
    sb.push_back(q);
    tick();
    g2 = sample();
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t g1, g2, e;
    reset = 1'b1; start = 1'b0; press = '0; act = '0;
    tick(); tick();
    sb.push_back(mk(0, 0, 6'h3f, 12'haaa, 0, 0, 0, 0));
    g1 = sample();
    e = sb.pop_front();
    total++;
    if (g1 !== e) $display("FAIL reset got=%h expected=%h", g1, e);
    else passed++;
    reset = 1'b0;
    rows.push_back(mkrow(6'h3f, NX, 0, mk(0, 0, 6'h3f, 12'haaa, 0, 0, 0, 0)));
    rows.push_back(mkrow(6'h01, SK, 0, mk(0, 0, 6'h3f, 12'haaa, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i], g1, g2);
      e = sb.pop_front(); total++;
      if (g1 !== e) $display("FAIL idle_press[%0d] got=%h expected=%h", i, g1, e);
      else passed++;
      e = sb.pop_front(); total++;
      if (g2 !== e) $display("FAIL idle_release[%0d] got=%h expected=%h", i, g2, e);
      else passed++;
    end
  endtask

  task automatic test_moves();
    row_t rows[$];
    obs_t g1, g2, e;
    rows.push_back(mkrow(6'h00, NX, 1, mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h01, NX, 0, mk(1, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h02, SK, 0, mk(3, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h08, HD, 0, mk(3, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h08, RV, 0, mk(2, 1, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h04, NX, 0, mk(1, 1, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h02, NX, 0, mk(0, 1, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h01, NX, 0, mk(5, 1, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i], g1, g2);
      e = sb.pop_front(); total++;
      if (g1 !== e) $display("FAIL moves[%0d] got=%h expected=%h", i, g1, e);
      else passed++;
      e = sb.pop_front(); total++;
      if (g2 !== e) $display("FAIL moves_release[%0d] got=%h expected=%h", i, g2, e);
      else passed++;
    end
  endtask

  task automatic test_fouls();
    row_t rows[$];
    obs_t g1, g2, e;
    rows.push_back(mkrow(6'h20, RV, 0, mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h01, NX, 0, mk(1, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h10, NX, 0, mk(1, 0, 6'h3f, 12'h9aa, 1, 6'h10, 1, 0)));
    rows.push_back(mkrow(6'h10, NX, 0, mk(1, 0, 6'h2f, 12'h8aa, 1, 6'h10, 1, 0)));
    rows.push_back(mkrow(6'h02, NX, 0, mk(2, 0, 6'h2f, 12'h8aa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h04, NX, 0, mk(3, 0, 6'h2f, 12'h8aa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h08, NX, 0, mk(5, 0, 6'h2f, 12'h8aa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h10, NX, 0, mk(5, 0, 6'h2f, 12'h8aa, 0, 0, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i], g1, g2);
      e = sb.pop_front(); total++;
      if (g1 !== e) $display("FAIL fouls[%0d] got=%h expected=%h", i, g1, e);
      else passed++;
      e = sb.pop_front(); total++;
      if (g2 !== e) $display("FAIL fouls_release[%0d] got=%h expected=%h", i, g2, e);
      else passed++;
    end
  endtask

  task automatic test_same_edge();
    row_t rows[$];
    obs_t g1, g2, e;
    rows.push_back(mkrow(6'h02, NX, 0, mk(5, 0, 6'h2f, 12'h8a6, 1, 6'h02, 1, 0)));
    rows.push_back(mkrow(6'h20, NX, 0, mk(0, 0, 6'h2f, 12'h8a6, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h03, NX, 0, mk(2, 0, 6'h2d, 12'h8a2, 1, 6'h02, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i], g1, g2);
      e = sb.pop_front(); total++;
      if (g1 !== e) $display("FAIL same_edge[%0d] got=%h expected=%h", i, g1, e);
      else passed++;
      e = sb.pop_front(); total++;
      if (g2 !== e) $display("FAIL same_edge_release[%0d] got=%h expected=%h", i, g2, e);
      else passed++;
    end
  endtask

  task automatic test_game_over();
    row_t rows[$];
    obs_t g1, g2, e;
    rows.push_back(mkrow(6'h01, NX, 0, mk(2, 0, 6'h2d, 12'h8a1, 1, 6'h01, 1, 0)));
    rows.push_back(mkrow(6'h01, NX, 0, mk(2, 0, 6'h2c, 12'h8a0, 1, 6'h01, 1, 0)));
    rows.push_back(mkrow(6'h08, NX, 0, mk(2, 0, 6'h2c, 12'h860, 1, 6'h08, 1, 0)));
    rows.push_back(mkrow(6'h08, NX, 0, mk(2, 0, 6'h24, 12'h820, 1, 6'h08, 1, 0)));
    rows.push_back(mkrow(6'h20, NX, 0, mk(2, 0, 6'h24, 12'h420, 1, 6'h20, 1, 0)));
    rows.push_back(mkrow(6'h20, NX, 0, mk(2, 0, 6'h04, 12'h020, 1, 6'h20, 2, 2)));
    rows.push_back(mkrow(6'h04, NX, 0, mk(2, 0, 6'h04, 12'h020, 0, 0, 2, 2)));
    rows.push_back(mkrow(6'h3f, SK, 0, mk(2, 0, 6'h04, 12'h020, 0, 0, 2, 2)));
    rows.push_back(mkrow(6'h00, NX, 1, mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i], g1, g2);
      e = sb.pop_front(); total++;
      if (g1 !== e) $display("FAIL game_over[%0d] got=%h expected=%h", i, g1, e);
      else passed++;
      e = sb.pop_front(); total++;
      if (g2 !== e) $display("FAIL game_over_release[%0d] got=%h expected=%h", i, g2, e);
      else passed++;
    end
  endtask

  task automatic test_reset_play();
    row_t rows[$];
    obs_t g1, g2, e;
    rows.push_back(mkrow(6'h01, NX, 0, mk(1, 0, 6'h3f, 12'haaa, 0, 0, 1, 0)));
    rows.push_back(mkrow(6'h04, NX, 0, mk(1, 0, 6'h3f, 12'ha9a, 1, 6'h04, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i], g1, g2);
      e = sb.pop_front(); total++;
      if (g1 !== e) $display("FAIL pre_reset[%0d] got=%h expected=%h", i, g1, e);
      else passed++;
      e = sb.pop_front(); total++;
      if (g2 !== e) $display("FAIL pre_reset_release[%0d] got=%h expected=%h", i, g2, e);
      else passed++;
    end
    // Reset mid-game with press[3] held high through reset and restart.
    reset = 1'b1; press = 6'h08;
    sb.push_back(mk(0, 0, 6'h3f, 12'haaa, 0, 0, 0, 0));
    tick();
    g1 = sample(); e = sb.pop_front(); total++;
    if (g1 !== e) $display("FAIL reset_in_play got=%h expected=%h", g1, e);
    else passed++;
    reset = 1'b0; start = 1'b1;
    sb.push_back(mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0));
    tick();
    start = 1'b0;
    g1 = sample(); e = sb.pop_front(); total++;
    if (g1 !== e) $display("FAIL restart got=%h expected=%h", g1, e);
    else passed++;
    sb.push_back(mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0));
    tick();
    g1 = sample(); e = sb.pop_front(); total++;
    if (g1 !== e) $display("FAIL held_no_edge got=%h expected=%h", g1, e);
    else passed++;
    press = '0;
    tick();
    press = 6'h08;
    sb.push_back(mk(0, 0, 6'h3f, 12'haa6 ^ 12'h0cc ^ 12'h000, 1, 6'h08, 1, 0));
    tick();
    press = '0;
    g1 = sample(); e = sb.pop_front(); total++;
    if (g1 !== e) $display("FAIL repress_edge got=%h expected=%h", g1, e);
    else passed++;
  endtask

  task automatic test_timeout();
    obs_t g, e;
    reset = 1'b1; press = '0; start = 1'b0;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef TURN_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) sb.push_back(mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0));
      else       sb.push_back(mk(1, 0, 6'h3f, 12'haa9, 1, 6'h01, 1, 0));
      tick();
      g = sample(); e = sb.pop_front(); total++;
      if (g !== e) $display("FAIL timeout[%0d] got=%h expected=%h", k, g, e);
      else passed++;
    end
`else
    for (int k = 1; k <= 20; k++) begin
      sb.push_back(mk(0, 0, 6'h3f, 12'haaa, 0, 0, 1, 0));
      tick();
      g = sample(); e = sb.pop_front(); total++;
      if (g !== e) $display("FAIL no_timeout[%0d] got=%h expected=%h", k, g, e);
      else passed++;
    end
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; press = '0; act = '0;
    test_reset();
    test_moves();
    test_fouls();
    test_same_edge();
    test_game_over();
    test_reset_play();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
